arbitro_rr_4: RTL and testbench
===============================

ARBITRO_RR_4 -- requirements
Module: arbitro_rr_4

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive grant cycles before preemption; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 en  input  1  arbitration enable; 0 blocks new grants only.
REQ-005 R0, R1, R2, R3  input  1 each  request lines, active-high, scalar.
REQ-006 G0, G1, G2, G3  output  1 each  registered grant lines, one-hot or all-zero.
REQ-007 A  output  1  MSB of the granted index.
REQ-008 B  output  1  LSB of the granted index.
REQ-009 valid  output  1  high while any Gk is high.

Function
REQ-010 The block SHALL implement a two-state FSM: OCIOSO (no grant) and CONCEDIDO (one grant active).
REQ-011 The block SHALL hold a 2-bit pointer ptr holding the last granted index, and a 4-bit hold counter hold_cnt.
REQ-012 In OCIOSO with en=1 and any Rk=1, the block SHALL select the first requester in the order ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-013 On that selection, the block SHALL, at the next edge, set Gk=1, {A,B}=k, valid=1, ptr=k, hold_cnt=1, and enter CONCEDIDO; grant latency is 1 cycle from a sampled request.
REQ-014 In OCIOSO with en=0 or all Rk=0, the block SHALL keep all outputs at 0 and leave ptr unchanged.
REQ-015 In CONCEDIDO, if the sampled Rk of the granted requester is 0, the block SHALL clear Gk, A, B and valid at the next edge and return to OCIOSO.
REQ-016 In CONCEDIDO, if hold_cnt==MAX_HOLD and any other Rj=1, the block SHALL release the grant at the next edge and return to OCIOSO (preemption).
REQ-017 In CONCEDIDO, if hold_cnt==MAX_HOLD and no other request is pending, the block SHALL keep the grant with hold_cnt saturated at MAX_HOLD.
REQ-018 Otherwise in CONCEDIDO, the block SHALL keep the grant and increment hold_cnt by 1.
REQ-019 Every release SHALL be followed by at least one OCIOSO cycle with all Gk=0 (dead cycle) before any new grant.
REQ-020 en=0 during CONCEDIDO SHALL NOT revoke the current grant; release follows REQ-015/016 only.
REQ-021 Invariant: at all times Gk = valid & ({A,B}==k) for k=0..3, and at most one Gk=1.
REQ-022 When valid=0, A and B SHALL be 0.
REQ-023 When requests rise in the same cycle as a release, they SHALL NOT be granted until the edge after the dead cycle.
REQ-024 The block SHALL have no combinational path from Rk or en to any output.

Reset
REQ-025 With rst_n=0 at a rising edge, the block SHALL set state=OCIOSO, G0..G3=0, A=B=0, valid=0, hold_cnt=0, ptr=3 (first priority is index 0).
REQ-026 Reset asserted mid-grant SHALL clear all outputs at that edge, regardless of en or Rk.
REQ-027 The first grant after reset release SHALL follow REQ-012 with ptr=3.

Verification
REQ-028 The bench SHALL hold rst_n=0 for 2 cycles with R0..R3=1 -> all outputs 0; after release, G0=1, {A,B}=00, valid=1 one cycle later.
REQ-029 The bench SHALL pulse R2=1 for 3 cycles, others 0 -> G2=1, {A,B}=10 for 3 cycles starting 1 cycle after R2 rises; 0 from the edge after R2 falls.
REQ-030 The bench SHALL hold R0..R3=1 continuously with MAX_HOLD=8 -> grant order 0,1,2,3,0; each grant lasts 8 cycles; exactly 1 dead cycle between grants.
REQ-031 The bench SHALL hold R1 alone for 20 cycles -> G1 stays high for 20 cycles with no dead cycle; hold_cnt saturates at 8.
REQ-032 The bench SHALL drive en=0 with R3=1 -> no grant; en=1 -> G3 one cycle later; en=0 while granted -> G3 retained until R3=0.
REQ-033 The bench SHALL drive rst_n=0 during a G2 grant with R1=R3=1 -> outputs cleared at that edge; after release, G1 granted first.

Source files
------------

// File: rtl/arbitro_rr_4.sv
// arbitro_rr_4: 4-way round-robin arbiter with hold limit and a dead cycle between grants
module arbitro_rr_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic R0,
    input  logic R1,
    input  logic R2,
    input  logic R3,
    output logic G0,
    output logic G1,
    output logic G2,
    output logic G3,
    output logic A,
    output logic B,
    output logic valid
);
    typedef enum logic {OCIOSO, CONCEDIDO} state_t;
    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
    state_t r_state, w_state_nx;
    logic [1:0] r_ptr, w_ptr_nx, w_sel;
    logic [3:0] r_hold, w_hold_nx;
    logic [3:0] w_req, w_others;
    assign w_req = {R3, R2, R1, R0};
    assign w_others = w_req & ~(4'b0001 << r_ptr);
    // Search ptr+1, ptr+2, ptr+3, ptr; iterating downward lets the nearest requester win
    always_comb begin
        w_sel = r_ptr;
        for (int i = 4; i >= 1; i--) if (w_req[r_ptr + 2'(i)]) w_sel = r_ptr + 2'(i);
    end
    // Next state: grant from idle, release on drop or on preemption at the hold limit
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx = r_ptr;
        w_hold_nx = r_hold;
        if (r_state == OCIOSO) begin
            if (en && |w_req) begin
                w_state_nx = CONCEDIDO;
                w_ptr_nx = w_sel;
                w_hold_nx = 4'd1;
            end
        end else if (!w_req[r_ptr] || (r_hold == HOLD_MAX && |w_others)) begin
            w_state_nx = OCIOSO;
            w_hold_nx = '0;
        end else if (r_hold != HOLD_MAX) begin
            w_hold_nx = r_hold + 4'd1;
        end
    end
    // State register; ptr resets to 3 so index 0 has first priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= OCIOSO;
            r_ptr <= 2'd3;
            r_hold <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ptr <= w_ptr_nx;
            r_hold <= w_hold_nx;
        end
    end
    // While granted, ptr is the granted index, so outputs decode straight from registers
    assign valid = (r_state == CONCEDIDO);
    assign {A, B} = valid ? r_ptr : 2'b00;
    assign G0 = valid && r_ptr == 2'd0;
    assign G1 = valid && r_ptr == 2'd1;
    assign G2 = valid && r_ptr == 2'd2;
    assign G3 = valid && r_ptr == 2'd3;
endmodule

// File: tb/tb_arbitro_rr_4.sv
// tb_arbitro_rr_4: vector table, corner sequences and random run against a reference model
module tb_arbitro_rr_4;
    localparam int MH = 8;
    logic clk = 1'b0;
    logic rst_n, en, R0, R1, R2, R3;
    logic G0, G1, G2, G3, A, B, valid;
    int n_checks = 0;
    int n_fail = 0;
    int m_g, m_ptr, m_hold;

    arbitro_rr_4 #(.MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .R0(R0), .R1(R1), .R2(R2), .R3(R3),
        .G0(G0), .G1(G1), .G2(G2), .G3(G3),
        .A(A), .B(B), .valid(valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rn;
        logic       e;
        logic [3:0] req;
        logic [3:0] g;
    } vec_t;

    function automatic logic [6:0] exp_vec(input logic [3:0] g);
        logic [1:0] ab;
        ab = g[3] ? 2'd3 : g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
        return {g, ab, |g};
    endfunction

    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] got;
        got = {G3, G2, G1, G0, A, B, valid};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got G3..G0,A,B,valid=%b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic rn, input logic e, input logic [3:0] r);
        rst_n = rn;
        en = e;
        {R3, R2, R1, R0} = r;
    endtask

    task automatic step_check(input string name, input logic [3:0] g);
        @(posedge clk);
        #1;
        check(name, exp_vec(g));
    endtask

    task automatic model_update();
        logic [3:0] req;
        req = {R3, R2, R1, R0};
        if (!rst_n) begin
            m_g = -1;
            m_ptr = 3;
            m_hold = 0;
        end else if (m_g < 0) begin
            if (en && req != 4'b0) begin
                for (int off = 1; off <= 4; off++) begin
                    int k;
                    k = (m_ptr + off) % 4;
                    if (req[k]) begin
                        m_g = k;
                        m_ptr = k;
                        m_hold = 1;
                        break;
                    end
                end
            end
        end else if (!req[m_g]) begin
            m_g = -1;
        end else if (m_hold == MH && (req & ~(4'd1 << m_g)) != 4'b0) begin
            m_g = -1;
        end else if (m_hold < MH) begin
            m_hold++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[18];
        logic [3:0] rq;
        tbl = '{
            '{1'b0, 1'b1, 4'hF, 4'b0000},
            '{1'b0, 1'b1, 4'hF, 4'b0000},
            '{1'b1, 1'b1, 4'hF, 4'b0001},
            '{1'b1, 1'b1, 4'h0, 4'b0000},
            '{1'b1, 1'b1, 4'h4, 4'b0100},
            '{1'b1, 1'b1, 4'h4, 4'b0100},
            '{1'b1, 1'b1, 4'h4, 4'b0100},
            '{1'b1, 1'b1, 4'h0, 4'b0000},
            '{1'b1, 1'b0, 4'h8, 4'b0000},
            '{1'b1, 1'b0, 4'h8, 4'b0000},
            '{1'b1, 1'b1, 4'h8, 4'b1000},
            '{1'b1, 1'b0, 4'h8, 4'b1000},
            '{1'b1, 1'b0, 4'h8, 4'b1000},
            '{1'b1, 1'b0, 4'h0, 4'b0000},
            '{1'b1, 1'b1, 4'h1, 4'b0001},
            '{1'b1, 1'b1, 4'h2, 4'b0000},
            '{1'b1, 1'b1, 4'h2, 4'b0010},
            '{1'b1, 1'b1, 4'h0, 4'b0000}
        };
        drive(1'b0, 1'b1, 4'hF);
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rn, tbl[i].e, tbl[i].req);
            step_check($sformatf("table[%0d]", i), tbl[i].g);
        end

        drive(1'b0, 1'b1, 4'hF);
        step_check("rr_reset", 4'b0000);
        drive(1'b1, 1'b1, 4'hF);
        for (int n = 0; n < 5; n++) begin
            for (int c = 0; c < MH; c++) step_check($sformatf("rr_grant%0d_c%0d", n, c), 4'(1 << (n % 4)));
            if (n < 4) step_check($sformatf("rr_dead%0d", n), 4'b0000);
        end

        drive(1'b0, 1'b1, 4'h2);
        step_check("sat_reset", 4'b0000);
        drive(1'b1, 1'b1, 4'h2);
        for (int c = 0; c < 20; c++) step_check($sformatf("sat_hold_c%0d", c), 4'b0010);
        drive(1'b1, 1'b1, 4'h3);
        step_check("sat_preempt", 4'b0000);
        step_check("sat_next_grant", 4'b0001);

        drive(1'b0, 1'b1, 4'h0);
        step_check("midrst_reset", 4'b0000);
        drive(1'b1, 1'b1, 4'h4);
        step_check("midrst_g2_a", 4'b0100);
        step_check("midrst_g2_b", 4'b0100);
        drive(1'b0, 1'b1, 4'hE);
        step_check("midrst_clear", 4'b0000);
        drive(1'b1, 1'b1, 4'hA);
        step_check("midrst_g1_first", 4'b0010);

        rq = 4'h0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
            drive((cyc == 0) ? 1'b0 : ($urandom_range(0, 99) != 0), $urandom_range(0, 3) != 0, rq);
            @(posedge clk);
            model_update();
            #1;
            check("rand_model", exp_vec(m_g < 0 ? 4'b0000 : 4'(1 << m_g)));
            n_checks++;
            if ($countones({G3, G2, G1, G0}) > 1 || (!valid && {A, B} != 2'b00)) begin
                n_fail++;
                $display("FAIL rand_invariant: got G=%b AB=%b valid=%b expected at most one grant and AB=00 when idle", {G3, G2, G1, G0}, {A, B}, valid);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
